// File: rtl/div_nonrestoring_seq.sv
// Sequential non-restoring unsigned divider: one quotient bit per clock, DVD_W+2 cycles start-to-done.
// start is taken only in IDLE; a zero divisor finishes in one cycle with dbz set and an all-ones quotient.
module div_nonrestoring_seq #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] a,
    input  logic [DVS_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quot,
    output logic [DVS_W-1:0] rem,
    output logic             dbz
);
    localparam int CNT_W = $clog2(DVD_W);

    typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

    state_t           state_q;
    logic [DVS_W:0]   p_q;
    logic [DVS_W:0]   p_d;
    logic [DVS_W:0]   p_sh;
    logic [DVS_W:0]   b_ext;
    logic [DVD_W-1:0] q_q;
    logic [DVD_W-1:0] q_d;
    logic [DVS_W-1:0] b_q;
    logic [DVS_W-1:0] rem_d;
    logic [CNT_W-1:0] cnt_q;

    // P is kept modulo 2^(DVS_W+1); the true value always lies in [-b, b), so wrap in the shift is harmless.
    always_comb begin
        b_ext = {1'b0, b_q};
        p_sh  = {p_q[DVS_W-1:0], q_q[DVD_W-1]};
        p_d   = p_q[DVS_W] ? (p_sh + b_ext) : (p_sh - b_ext);
        q_d   = {q_q[DVD_W-2:0], ~p_d[DVS_W]};
        rem_d = p_q[DVS_W] ? (p_q[DVS_W-1:0] + b_q) : p_q[DVS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        b_q <= b;
                        if (b == '0) begin
                            dbz     <= 1'b1;
                            quot    <= '1;
                            rem     <= '0;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dbz     <= 1'b0;
                            busy    <= 1'b1;
                            p_q     <= '0;
                            q_q     <= a;
                            cnt_q   <= CNT_W'(DVD_W - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= CORR;
                    end
                end
                CORR: begin
                    p_q     <= p_q[DVS_W] ? (p_q + b_ext) : p_q;
                    quot    <= q_q;
                    rem     <= rem_d;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
